// File: rtl/generic_table_lookup_pkg.sv
// Shared types for the generic table lookup block.
//   state_e : one-hot controller states (sweep, normal service, software ack cycle)
//   sel_e   : which requester owns the single RAM port in a given cycle
package generic_table_lookup_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'b001,
    ST_IDLE   = 3'b010,
    ST_SW_ACK = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_LOOKUP = 2'd1,
    SEL_SW     = 2'd2
  } sel_e;

endpackage

// File: rtl/generic_table_ram.sv
// Single-port synchronous RAM with a registered read port (1-cycle latency).
//   clk  : clock
//   en   : port enable; with we=0 a read is launched, with we=1 a write
//   we   : write enable
//   addr : entry address
//   din  : write data
//   dout : read data, updated only by reads, holds otherwise
module generic_table_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage array and read register; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= din;
      end else begin
        dout <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/generic_table_lookup.sv
// Table storage behind the generic table register interface.
// A single-port RAM is shared between a datapath lookup port (normally
// preferred) and a software read/write request/ack port. A starvation
// counter forces a software grant after STARVE_LIMIT denied cycles. After
// reset every entry is swept to RESET_VALUE before any request is served.
//   clk, reset                      : clock, synchronous active-high reset
//   lookup_req/addr/rdy/ack/data    : datapath lookup (rdy combinational, ack 1 cycle after accept)
//   table_rd_req/addr/ack/data      : software read (level req, pulse ack)
//   table_wr_req/addr/data/ack      : software write (level req, pulse ack)
//   init_done                       : high once the init sweep has finished
module generic_table_lookup
  import generic_table_lookup_pkg::*;
#(
  parameter int                           TABLE_ENTRY_WIDTH = 8,
  parameter int                           TABLE_ADDR_WIDTH  = 8,
  parameter int                           STARVE_LIMIT      = 15,
  parameter logic [TABLE_ENTRY_WIDTH-1:0] RESET_VALUE       = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         lookup_req,
  input  logic [TABLE_ADDR_WIDTH-1:0]  lookup_addr,
  output logic                         lookup_rdy,
  output logic                         lookup_ack,
  output logic [TABLE_ENTRY_WIDTH-1:0] lookup_data,
  input  logic                         table_rd_req,
  input  logic [TABLE_ADDR_WIDTH-1:0]  table_rd_addr,
  output logic                         table_rd_ack,
  output logic [TABLE_ENTRY_WIDTH-1:0] table_rd_data,
  input  logic                         table_wr_req,
  input  logic [TABLE_ADDR_WIDTH-1:0]  table_wr_addr,
  input  logic [TABLE_ENTRY_WIDTH-1:0] table_wr_data,
  output logic                         table_wr_ack,
  output logic                         init_done
);

  localparam logic [TABLE_ADDR_WIDTH-1:0] PTR_LAST   = '1;
  localparam logic [7:0]                  STARVE_MAX = 8'(STARVE_LIMIT);

  state_e                         state_q, state_d;
  logic [TABLE_ADDR_WIDTH-1:0]    ptr_q, ptr_d;
  logic [7:0]                     starve_q, starve_d;
  logic                           init_done_q, init_done_d;
  logic                           lookup_ack_q, rd_ack_q, wr_ack_q;
  logic [TABLE_ENTRY_WIDTH-1:0]   lookup_hold_q, rd_hold_q;

  logic                           sw_pend, force_sw;
  sel_e                           sel;
  logic                           ram_en, ram_we;
  logic [TABLE_ADDR_WIDTH-1:0]    ram_addr;
  logic [TABLE_ENTRY_WIDTH-1:0]   ram_din, ram_dout;

  // Arbitration: lookup wins unless software has been starved to the limit.
  // SW_ACK never counts as pending, so the requester has a cycle to drop req.
  always_comb begin
    sw_pend    = (table_rd_req || table_wr_req) && (state_q == ST_IDLE);
    force_sw   = (starve_q == STARVE_MAX) && sw_pend;
    lookup_rdy = (state_q != ST_INIT) && !force_sw;
    if (lookup_req && lookup_rdy) begin
      sel = SEL_LOOKUP;
    end else if (sw_pend) begin
      sel = SEL_SW;
    end else begin
      sel = SEL_NONE;
    end
  end

  // RAM port steering; a simultaneous rd+wr request serves the write first.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = lookup_addr;
    ram_din  = table_wr_data;
    if (state_q == ST_INIT) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = ptr_q;
      ram_din  = RESET_VALUE;
    end else begin
      case (sel)
        SEL_LOOKUP: begin
          ram_en   = 1'b1;
          ram_addr = lookup_addr;
        end
        SEL_SW: begin
          ram_en   = 1'b1;
          ram_we   = table_wr_req;
          ram_addr = table_wr_req ? table_wr_addr : table_rd_addr;
        end
        default: begin
          ram_en = 1'b0;
        end
      endcase
    end
  end

  // Next-state logic for the controller, sweep pointer and starvation counter.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + TABLE_ADDR_WIDTH'(1);
        if (ptr_q == PTR_LAST) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (sel == SEL_SW) begin
          state_d = ST_SW_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SW_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        // Corrupted one-hot state: restart the sweep from scratch.
        state_d     = ST_INIT;
        ptr_d       = '0;
        init_done_d = 1'b0;
      end
    endcase

    // Pending and not granted implies a lookup took the port this cycle.
    if ((sel == SEL_SW) || !sw_pend) begin
      starve_d = 8'd0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State, ack pulses and last-valid data holders.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      ptr_q         <= '0;
      starve_q      <= 8'd0;
      init_done_q   <= 1'b0;
      lookup_ack_q  <= 1'b0;
      rd_ack_q      <= 1'b0;
      wr_ack_q      <= 1'b0;
      lookup_hold_q <= '0;
      rd_hold_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      starve_q     <= starve_d;
      init_done_q  <= init_done_d;
      lookup_ack_q <= (sel == SEL_LOOKUP);
      rd_ack_q     <= (sel == SEL_SW) && !table_wr_req;
      wr_ack_q     <= (sel == SEL_SW) && table_wr_req;
      if (lookup_ack_q) begin
        lookup_hold_q <= ram_dout;
      end
      if (rd_ack_q) begin
        rd_hold_q <= ram_dout;
      end
    end
  end

  generic_table_ram #(
    .WIDTH      (TABLE_ENTRY_WIDTH),
    .ADDR_WIDTH (TABLE_ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // The RAM read register is shared, so data ports show it only in their ack
  // cycle and otherwise replay the value captured at their last ack.
  assign lookup_ack    = lookup_ack_q;
  assign lookup_data   = lookup_ack_q ? ram_dout : lookup_hold_q;
  assign table_rd_ack  = rd_ack_q;
  assign table_rd_data = rd_ack_q ? ram_dout : rd_hold_q;
  assign table_wr_ack  = wr_ack_q;
  assign init_done     = init_done_q;

endmodule
